// File: rtl/exc_pkg.sv
// Shared definitions for the MEM-stage exception logic: cause codes,
// detector address bounds, FSM encoding and default vector-table addresses.
package exc_pkg;

  localparam logic [1:0] EXC_NONE    = 2'b00;
  localparam logic [1:0] EXC_INVALID = 2'b01;
  localparam logic [1:0] EXC_PROTECT = 2'b10;

  // Bounds used by the detector HDU; kept here so both sides agree.
  localparam logic [31:0] ADDR_INVALID_MIN = 32'h0010_0000;
  localparam logic [31:0] ADDR_PROTECT_LO  = 32'h0000_FF00;
  localparam logic [31:0] ADDR_PROTECT_HI  = 32'h0001_0000;

  localparam logic [31:0] VEC_INVALID_DEF = 32'h0000_0002;
  localparam logic [31:0] VEC_PROTECT_DEF = 32'h0000_0004;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FLUSH,
    S_FETCH,
    S_REDIRECT
  } exc_state_t;

  // Code 11 is reserved and never accepted.
  function automatic logic is_exception(input logic [1:0] code);
    return (code == EXC_INVALID) || (code == EXC_PROTECT);
  endfunction

endpackage

// File: rtl/exc_mem_if.sv
// Vector-table read channel: request/acknowledge handshake with address and data.
interface exc_mem_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/exc_flush_counter.sv
// Loadable 4-bit down-counter; done marks the final counted cycle (count == 1).
module exc_flush_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       dec,
  output logic [3:0] count,
  output logic       done
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 4'd0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != 4'd0)) begin
      count <= count - 4'd1;
    end
  end

  assign done = (count == 4'd1);

endmodule

// File: rtl/exception_handler.sv
// Memory-exception responder: saves EPC/cause, flushes the pipeline, fetches
// the handler vector, redirects the PC, and returns to EPC on RTI.
module exception_handler
  import exc_pkg::*;
#(
  parameter logic [31:0] VEC_INVALID  = VEC_INVALID_DEF,
  parameter logic [31:0] VEC_PROTECT  = VEC_PROTECT_DEF,
  parameter int unsigned FLUSH_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  i_changeEPC,
  input  logic [31:0] i_pc,
  input  logic        i_rti,
  exc_mem_if.master   mem,
  output logic        o_flush,
  output logic        o_stall,
  output logic        o_pc_load,
  output logic [31:0] o_pc_value,
  output logic [31:0] o_epc,
  output logic [1:0]  o_cause,
  output logic        o_busy
);

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  exc_state_t state;
  logic       take_exc;
  logic [3:0] flush_count;
  logic       flush_done;

  // Exceptions are only accepted from IDLE; anything raised while busy
  // belongs to an instruction that is being flushed.
  assign take_exc = (state == S_IDLE) && is_exception(i_changeEPC);

  exc_flush_counter u_flush_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (take_exc),
    .load_val (FLUSH_LOAD),
    .dec      (state == S_FLUSH),
    .count    (flush_count),
    .done     (flush_done)
  );

  // NOTE: every output register, EPC and cause included, is cleared by the
  // asynchronous reset so a reset mid-fetch drops the request immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      o_flush      <= 1'b0;
      o_stall      <= 1'b0;
      o_pc_load    <= 1'b0;
      o_pc_value   <= 32'd0;
      o_epc        <= 32'd0;
      o_cause      <= EXC_NONE;
      o_busy       <= 1'b0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          o_pc_load <= 1'b0;
          if (take_exc) begin
            o_epc   <= i_pc;
            o_cause <= i_changeEPC;
            o_flush <= 1'b1;
            o_stall <= 1'b1;
            o_busy  <= 1'b1;
            state   <= S_FLUSH;
          end else if (i_rti) begin
            o_pc_load  <= 1'b1;
            o_pc_value <= o_epc;
          end
        end
        S_FLUSH: begin
          if (flush_done) begin
            o_flush      <= 1'b0;
            mem.mem_req  <= 1'b1;
            mem.mem_addr <= (o_cause == EXC_INVALID) ? VEC_INVALID : VEC_PROTECT;
            state        <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (mem.mem_ack) begin
            o_pc_value  <= mem.mem_rdata;
            mem.mem_req <= 1'b0;
            o_stall     <= 1'b0;
            o_pc_load   <= 1'b1;
            state       <= S_REDIRECT;
          end
        end
        S_REDIRECT: begin
          o_pc_load <= 1'b0;
          o_busy    <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_handler.sv
// Directed bench for exception_handler: per-exception expectations are queued
// when the exception is raised and compared once the redirect is observed.
module tb_exception_handler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  i_changeEPC = 2'b00;
  logic [31:0] i_pc = 32'd0;
  logic        i_rti = 1'b0;
  logic        o_flush, o_stall, o_pc_load, o_busy;
  logic [31:0] o_pc_value, o_epc;
  logic [1:0]  o_cause;

  exc_mem_if mem_bus ();

  exception_handler #(
    .VEC_INVALID  (32'h0000_0002),
    .VEC_PROTECT  (32'h0000_0004),
    .FLUSH_CYCLES (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_changeEPC (i_changeEPC),
    .i_pc        (i_pc),
    .i_rti       (i_rti),
    .mem         (mem_bus.master),
    .o_flush     (o_flush),
    .o_stall     (o_stall),
    .o_pc_load   (o_pc_load),
    .o_pc_value  (o_pc_value),
    .o_epc       (o_epc),
    .o_cause     (o_cause),
    .o_busy      (o_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] epc;
    logic [31:0] cause;
    logic [31:0] addr;
    logic [31:0] vec;
    int          latency;
    int          flushes;
    int          reqs;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raise one exception and watch it through to the redirect. Optionally
  // injects a second exception plus RTI during the first FLUSH cycle.
  task automatic run_exc(input logic [1:0] code, input logic [31:0] pc, input int ack_delay,
                         input logic [31:0] rdata, input logic rti_same, input logic inject);
    exp_t e, got;
    int   fcnt, rcnt, lat;
    logic [31:0] addr_seen;
    logic        addr_stable;
    e.epc     = pc;
    e.cause   = {30'd0, code};
    e.addr    = (code == 2'b01) ? 32'h2 : 32'h4;
    e.vec     = rdata;
    e.latency = 5 + ack_delay;
    e.flushes = 3;
    e.reqs    = ack_delay + 1;
    sb.push_back(e);
    @(negedge clk);
    i_changeEPC = code;
    i_pc        = pc;
    i_rti       = rti_same;
    fcnt = 0; rcnt = 0; lat = 0; addr_seen = 32'd0; addr_stable = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      i_changeEPC = 2'b00;
      i_rti       = 1'b0;
      mem_bus.mem_ack = 1'b0;
      if (inject && cyc == 1) begin
        i_changeEPC = 2'b01;
        i_pc        = 32'h99;
        i_rti       = 1'b1;
      end
      if (o_flush) fcnt++;
      if (mem_bus.mem_req) begin
        rcnt++;
        if (rcnt == 1) addr_seen = mem_bus.mem_addr;
        else if (mem_bus.mem_addr !== addr_seen) addr_stable = 1'b0;
        if (rcnt == ack_delay + 1) begin
          mem_bus.mem_ack   = 1'b1;
          mem_bus.mem_rdata = rdata;
        end
      end
      if (o_pc_load) begin
        lat = cyc;
        break;
      end
    end
    got.epc = o_epc; got.cause = {30'd0, o_cause}; got.addr = addr_seen;
    got.vec = o_pc_value; got.latency = lat; got.flushes = fcnt; got.reqs = rcnt;
    @(negedge clk);
    e = sb.pop_front();
    check("load_latency", 32'(got.latency), 32'(e.latency));
    check("pc_value",     got.vec,          e.vec);
    check("epc",          got.epc,          e.epc);
    check("cause",        got.cause,        e.cause);
    check("flush_cycles", 32'(got.flushes), 32'(e.flushes));
    check("req_cycles",   32'(got.reqs),    32'(e.reqs));
    check("mem_addr",     got.addr,         e.addr);
    check("addr_stable",  32'(addr_stable), 32'd1);
    check("busy_after",   32'(o_busy),      32'd0);
    check("load_after",   32'(o_pc_load),   32'd0);
  endtask

  initial begin
    mem_bus.mem_ack   = 1'b0;
    mem_bus.mem_rdata = 32'd0;
    #2;
    check("rst_outputs", {26'd0, o_flush, o_stall, o_pc_load, o_busy,
                          mem_bus.mem_req, |o_cause}, 32'd0);
    check("rst_epc",     o_epc,            32'd0);
    check("rst_pc_val",  o_pc_value,       32'd0);
    check("rst_addr",    mem_bus.mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reserved code and a stray ack in IDLE must change nothing.
    @(negedge clk);
    i_changeEPC = 2'b11;
    i_pc        = 32'h55;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hDEAD;
    @(negedge clk);
    i_changeEPC = 2'b00;
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    check("code11_busy",  32'(o_busy),  32'd0);
    check("code11_flush", 32'(o_flush), 32'd0);
    check("code11_epc",   o_epc,        32'd0);
    check("code11_cause", 32'(o_cause), 32'd0);
    check("stray_req",    32'(mem_bus.mem_req), 32'd0);
    check("stray_load",   32'(o_pc_load), 32'd0);
    check("stray_pcval",  o_pc_value,   32'd0);

    // Invalid-address exception with a second exception + RTI during FLUSH.
    run_exc(2'b01, 32'h40, 0, 32'h200, 1'b0, 1'b1);

    // RTI returns to EPC for exactly one cycle.
    i_rti = 1'b1;
    @(negedge clk);
    i_rti = 1'b0;
    check("rti_load",  32'(o_pc_load), 32'd1);
    check("rti_value", o_pc_value,     32'h40);
    check("rti_busy",  32'(o_busy),    32'd0);
    @(negedge clk);
    check("rti_one_cycle", 32'(o_pc_load), 32'd0);
    check("rti_epc_kept",  o_epc,          32'h40);

    // Protected-region exception with ack delayed by four cycles.
    run_exc(2'b10, 32'h88, 4, 32'h300, 1'b0, 1'b0);

    // Exception and RTI together in IDLE: exception wins.
    run_exc(2'b10, 32'h120, 1, 32'h440, 1'b1, 1'b0);

    // Asynchronous reset in the middle of FETCH.
    @(negedge clk);
    i_changeEPC = 2'b01;
    i_pc        = 32'h70;
    @(negedge clk);
    i_changeEPC = 2'b00;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (mem_bus.mem_req) break;
      @(negedge clk);
    end
    check("fetch_reached", 32'(mem_bus.mem_req), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_req_drop", 32'(mem_bus.mem_req), 32'd0);
    check("async_busy",     32'(o_busy),          32'd0);
    check("async_epc",      o_epc,                32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    mem_bus.mem_ack   = 1'b1;
    mem_bus.mem_rdata = 32'hBEEF;
    @(negedge clk);
    mem_bus.mem_ack = 1'b0;
    @(negedge clk);
    check("late_ack_req",   32'(mem_bus.mem_req), 32'd0);
    check("late_ack_load",  32'(o_pc_load),       32'd0);
    check("late_ack_pcval", o_pc_value,           32'd0);
    check("late_ack_busy",  32'(o_busy),          32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
